// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the E stage: fixed-latency countdown, then HI/LO write.
// Optional MD_EARLY_ZERO_EN: zero-operand mult / divide-by-zero finish after one busy cycle.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dbg_state
);

  // Handshake: start is sampled only in IDLE and only when flush is low; busy
  // rises the cycle after acceptance, so the hazard unit must OR in start itself.
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          done_q, done_d;
  logic          early_zero;

  // Result datapath works only from latched operands.
  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};

  // Signed divide through magnitudes keeps 0x80000000 / -1 well defined.
  assign mag_a = a_q[31] ? (32'd0 - a_q) : a_q;
  assign mag_b = b_q[31] ? (32'd0 - b_q) : b_q;
  assign q_mag = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
  assign r_mag = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
  assign quo_s = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
  assign rem_s = a_q[31] ? (32'd0 - r_mag) : r_mag;
  assign quo_u = (b_q == 32'd0) ? 32'd0 : a_q / b_q;
  assign rem_u = (b_q == 32'd0) ? 32'd0 : a_q % b_q;

  always_comb begin
`ifdef MD_EARLY_ZERO_EN
    early_zero = md_op[1] ? (rt_val == 32'd0) : ((rs_val == 32'd0) || (rt_val == 32'd0));
`else
    early_zero = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (md_op)
            4'd0, 4'd1, 4'd2, 4'd3: begin
              op_d    = md_op[1:0];
              a_d     = rs_val;
              b_d     = rt_val;
              state_d = S_RUN;
              if (early_zero)    cnt_d = CW'(1);
              else if (md_op[1]) cnt_d = CW'(DIV_CYCLES);
              else               cnt_d = CW'(MULT_CYCLES);
            end
            4'd4:    hi_d = rs_val;
            4'd5:    lo_d = rs_val;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          case (op_q)
            2'd0: {hi_d, lo_d} = prod_s;
            2'd1: {hi_d, lo_d} = prod_u;
            2'd2: if (b_q != 32'd0) {hi_d, lo_d} = {rem_s, quo_s};
            default: if (b_q != 32'd0) {hi_d, lo_d} = {rem_u, quo_u};
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed vector table, hand-written corner sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_md_sequencer;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef MD_EARLY_ZERO_EN
  localparam bit EZ = 1'b1;
`else
  localparam bit EZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        flush;
  logic        busy, done, dbg_state;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;

  md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference model: what HI/LO, busy length and done should be for one op
  task automatic model(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output logic [31:0] e_hi, output logic [31:0] e_lo,
                       output int e_busy, output bit e_done);
    longint          p, sa, sb, q, r;
    longint unsigned pu;
    e_hi = mdl_hi; e_lo = mdl_lo; e_busy = 0; e_done = 1'b0;
    case (op)
      4'd0: begin
        p = longint'($signed(rs)) * longint'($signed(rt));
        e_hi = p[63:32]; e_lo = p[31:0];
        e_busy = (EZ && (rs == 0 || rt == 0)) ? 1 : MULT_N; e_done = 1'b1;
      end
      4'd1: begin
        pu = longint'({32'b0, rs}) * longint'({32'b0, rt});
        e_hi = pu[63:32]; e_lo = pu[31:0];
        e_busy = (EZ && (rs == 0 || rt == 0)) ? 1 : MULT_N; e_done = 1'b1;
      end
      4'd2: begin
        if (rt != 0) begin
          sa = longint'($signed(rs)); sb = longint'($signed(rt));
          q = sa / sb; r = sa % sb;
          e_hi = r[31:0]; e_lo = q[31:0];
        end
        e_busy = (EZ && rt == 0) ? 1 : DIV_N; e_done = 1'b1;
      end
      4'd3: begin
        if (rt != 0) begin
          e_lo = rs / rt; e_hi = rs % rt;
        end
        e_busy = (EZ && rt == 0) ? 1 : DIV_N; e_done = 1'b1;
      end
      4'd4: e_hi = rs;
      4'd5: e_lo = rs;
      default: ;
    endcase
  endtask

  // driver: issue one op, measure busy length, check done pulse and HI/LO
  task automatic apply(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] e_hi, input logic [31:0] e_lo,
                       input int e_busy, input bit e_done, input string tag);
    logic [31:0] hi1, lo1;
    int cnt;
    bit glitch;
    @(negedge clk);
    start = 1'b1; md_op = op; rs_val = rs; rt_val = rt; flush = 1'b0;
    @(negedge clk);
    start = 1'b0; md_op = 4'($urandom_range(0, 15));
    rs_val = $urandom; rt_val = $urandom; flush = 1'($urandom_range(0, 1));
    hi1 = hi; lo1 = lo; cnt = 0; glitch = 1'b0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (hi !== hi1 || lo !== lo1 || done !== 1'b0) glitch = 1'b1;
      @(negedge clk);
    end
    flush = 1'b0;
    chk({tag, " busy_cycles"}, 32'(cnt), 32'(e_busy));
    chk({tag, " done"}, 32'(done), 32'(e_done));
    chk({tag, " hi"}, hi, e_hi);
    chk({tag, " lo"}, lo, e_lo);
    chk({tag, " stable_while_busy"}, 32'(glitch), 32'd0);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
    mdl_hi = e_hi; mdl_lo = e_lo;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs, rt, e_hi, e_lo;
    int          e_busy;
    bit          e_done;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] e_hi, e_lo, rs, rt;
    logic [3:0]  op;
    int e_busy, cnt;
    bit e_done, bad;

    vecs[0]  = '{4'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MULT_N, 1'b1};
    vecs[1]  = '{4'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_N, 1'b1};
    vecs[2]  = '{4'd3, 32'd7,        32'd2,        32'd1,        32'd3,        DIV_N, 1'b1};
    vecs[3]  = '{4'd4, 32'h1234,     32'd9,        32'h1234,     32'd3,        0, 1'b0};
    vecs[4]  = '{4'd5, 32'h55,       32'd9,        32'h1234,     32'h55,       0, 1'b0};
    vecs[5]  = '{4'd2, 32'd9,        32'd0,        32'h1234,     32'h55,       EZ ? 1 : DIV_N, 1'b1};
    vecs[6]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DIV_N, 1'b1};
    vecs[7]  = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MULT_N, 1'b1};
    vecs[8]  = '{4'd0, 32'd0,        32'd12345,    32'd0,        32'd0,        EZ ? 1 : MULT_N, 1'b1};
    vecs[9]  = '{4'd7, 32'hAAAA,     32'd1,        32'd0,        32'd0,        0, 1'b0};
    vecs[10] = '{4'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DIV_N, 1'b1};
    vecs[11] = '{4'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        MULT_N, 1'b1};
    vecs[12] = '{4'd3, 32'd5,        32'd0,        32'h40000000, 32'd0,        EZ ? 1 : DIV_N, 1'b1};

    reset = 1'b1; start = 1'b0; md_op = '0; rs_val = '0; rt_val = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++)
      apply(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].e_hi, vecs[i].e_lo,
            vecs[i].e_busy, vecs[i].e_done, $sformatf("vec%0d", i));

    // start together with flush: nothing happens, including MT writes
    @(negedge clk);
    start = 1'b1; md_op = 4'd0; rs_val = 32'd5; rt_val = 32'd6; flush = 1'b1;
    @(negedge clk);
    md_op = 4'd4; rs_val = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush done", 32'(done), 32'd0);
    chk("flush hi", hi, mdl_hi);
    chk("flush lo", lo, mdl_lo);

    // start during RUN is ignored
    @(negedge clk);
    start = 1'b1; md_op = 4'd2; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0; cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (cnt == 3) begin
        start = 1'b1; md_op = 4'd0; rs_val = 32'd2; rt_val = 32'd3;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("run_start busy_cycles", 32'(cnt), 32'(DIV_N));
    chk("run_start done", 32'(done), 32'd1);
    chk("run_start hi", hi, 32'd2);
    chk("run_start lo", lo, 32'd14);

    // back-to-back: start in first idle cycle
    @(negedge clk);
    start = 1'b1; md_op = 4'd1; rs_val = 32'd6; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0; cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("b2b first busy_cycles", 32'(cnt), 32'(MULT_N));
    chk("b2b first done", 32'(done), 32'd1);
    chk("b2b first lo", lo, 32'd42);
    start = 1'b1; md_op = 4'd3; rs_val = 32'd100; rt_val = 32'd9;
    @(negedge clk);
    start = 1'b0;
    chk("b2b second busy_rise", 32'(busy), 32'd1);
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("b2b second busy_cycles", 32'(cnt), 32'(DIV_N));
    chk("b2b second hi", hi, 32'd1);
    chk("b2b second lo", lo, 32'd11);

    // asynchronous reset in the middle of a DIV
    @(negedge clk);
    start = 1'b1; md_op = 4'd2; rs_val = 32'd1000; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset hi", hi, 32'd0);
    chk("midreset lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad = 1'b1;
    end
    chk("midreset no_late_write", 32'(bad), 32'd0);
    mdl_hi = '0; mdl_lo = '0;

    // randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      rs = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom;
      case ($urandom_range(0, 5))
        0:       rt = 32'd0;
        1:       rt = 32'($urandom_range(1, 17));
        2:       rt = 32'hFFFFFFFF;
        default: rt = $urandom;
      endcase
      model(op, rs, rt, e_hi, e_lo, e_busy, e_done);
      apply(op, rs, rt, e_hi, e_lo, e_busy, e_done, $sformatf("rnd%0d op%0d", i, op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
